// File: rtl/mem_io_bridge_if.sv
// CPU-side byte bus of the memory/IO bridge: request address/data in, read data and
// back-pressure out.
interface mem_io_bridge_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;

  modport master (
    output cpu_a,
    output cpu_wr,
    output cpu_dout,
    input  cpu_din,
    input  io_buffer_full
  );

  modport slave (
    input  cpu_a,
    input  cpu_wr,
    input  cpu_dout,
    output cpu_din,
    output io_buffer_full
  );
endinterface

// File: rtl/mem_io_bridge.sv
// Decodes CPU byte-bus cycles into RAM or the 0x3xxxx I/O window (UART TX FIFO, UART RX,
// snapshot cycle counter, program stop); every read returns data one cycle later.
module mem_io_bridge #(
  parameter int unsigned TX_FIFO_DEPTH  = 8,
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  mem_io_bridge_if.slave            cpu,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic                      ram_we,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_pop,
  output logic                      program_stop,
  output logic                      tx_overflow
);

  localparam int unsigned PtrW = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt    = CntW'(TX_FIFO_DEPTH);
  localparam logic [CntW-1:0] NearFullCnt = CntW'(TX_FIFO_DEPTH - 2);

  localparam logic [17:0] AddrUart  = 18'h30000;
  localparam logic [17:0] AddrCnt0  = 18'h30004;
  localparam logic [17:0] AddrCnt1  = 18'h30005;
  localparam logic [17:0] AddrCnt2  = 18'h30006;
  localparam logic [17:0] AddrCnt3  = 18'h30007;

  logic [17:0] io_addr;
  logic        is_io;
  logic        rd_io, wr_io;
  logic        tx_wr, push, pop, drop;

  logic            sel_q, sel_d;
  logic [7:0]      io_rdata_q, io_rdata_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     snap_q, snap_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            stop_pending_q, stop_pending_d;
  logic            program_stop_q, program_stop_d;
  logic            tx_overflow_q, tx_overflow_d;
  logic [7:0]      fifo_mem [TX_FIFO_DEPTH];

  // Upper address bits are outside the decoded space.
  logic unused_addr;
  assign unused_addr = ^cpu.cpu_a[31:18];

  assign io_addr = cpu.cpu_a[17:0];
  assign is_io   = (io_addr[17:16] == 2'b11);
  assign rd_io   = rdy_in & is_io & ~cpu.cpu_wr;
  assign wr_io   = rdy_in & is_io & cpu.cpu_wr;

  assign ram_a     = cpu.cpu_a[RAM_ADDR_WIDTH-1:0];
  assign ram_we    = rdy_in & ~is_io & cpu.cpu_wr;
  assign ram_wdata = cpu.cpu_dout;

  assign rx_pop   = rd_io & (io_addr == AddrUart) & rx_valid;
  assign tx_valid = (count_q != '0);
  assign tx_data  = fifo_mem[rd_ptr_q];

  // A 0x00 write to the UART port is a no-op, not a pushed byte.
  assign tx_wr = wr_io & (io_addr == AddrUart) & (cpu.cpu_dout != 8'h00);
  assign push  = tx_wr & (count_q != DepthCnt);
  assign drop  = tx_wr & (count_q == DepthCnt);
  assign pop   = tx_valid & tx_ready;

  assign cpu.cpu_din        = sel_q ? io_rdata_q : ram_rdata;
  // Two entries of headroom cover the write already in flight when the flag rises.
  assign cpu.io_buffer_full = (count_q >= NearFullCnt);
  assign program_stop       = program_stop_q;
  assign tx_overflow        = tx_overflow_q;

  always_comb begin
    sel_d          = sel_q;
    io_rdata_d     = io_rdata_q;
    snap_d         = snap_q;
    cnt_d          = cnt_q;
    stop_pending_d = stop_pending_q;
    if (rdy_in) begin
      cnt_d = cnt_q + 32'd1;
      sel_d = is_io;
    end
    if (rd_io) begin
      case (io_addr)
        AddrUart: io_rdata_d = rx_valid ? rx_data : 8'h00;
        AddrCnt0: begin
          snap_d     = cnt_q;
          io_rdata_d = cnt_q[7:0];
        end
        AddrCnt1: io_rdata_d = snap_q[15:8];
        AddrCnt2: io_rdata_d = snap_q[23:16];
        AddrCnt3: io_rdata_d = snap_q[31:24];
        default:  io_rdata_d = 8'h00;
      endcase
    end
    if (wr_io && (io_addr == AddrCnt0)) begin
      stop_pending_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    tx_overflow_d  = tx_overflow_q | drop;
    program_stop_d = program_stop_q | (stop_pending_q & (count_q == '0) & ~push);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_q          <= 1'b1;
      io_rdata_q     <= 8'h00;
      cnt_q          <= '0;
      snap_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      stop_pending_q <= 1'b0;
      program_stop_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      sel_q          <= sel_d;
      io_rdata_q     <= io_rdata_d;
      cnt_q          <= cnt_d;
      snap_q         <= snap_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      stop_pending_q <= stop_pending_d;
      program_stop_q <= program_stop_d;
      tx_overflow_q  <= tx_overflow_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q] <= cpu.cpu_dout;
  end

endmodule
